// File: rtl/event_scheduler_if.sv
// Evaluator-side request channel of the event scheduler.
// Carries the FIFO head (values, pacing mask, timestamp) under a
// valid/ready handshake.
//   ev_valid  : head entry available (scheduler -> evaluator)
//   ev_ready  : evaluator accepts head (evaluator -> scheduler)
//   ev_data   : head values, stream i at [i*DW +: DW]
//   ev_pacing : {deadline1, deadline0, input-new[N_IN-1:0]}
//   ev_ts     : head timestamp
interface event_scheduler_if #(
    parameter int N_IN = 2,
    parameter int DW   = 64,
    parameter int TS_W = 32
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic [N_IN*DW-1:0]   ev_data;
    logic [N_IN+1:0]      ev_pacing;
    logic [TS_W-1:0]      ev_ts;

    modport master (
        output ev_valid, ev_data, ev_pacing, ev_ts,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_data, ev_pacing, ev_ts,
        output ev_ready
    );
endinterface

// File: rtl/event_scheduler.sv
// Front-end scheduler for the stream monitor. Merges sporadic input
// events with two periodic deadlines into timestamped evaluation
// requests, buffered in a first-word-fall-through FIFO.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   en           : global enable; freezes counters, push and pop when 0
//   in_data      : input values, stream i at [i*DW +: DW]
//   in_new       : per-stream new-value strobe
//   ev           : evaluator handshake (master side)
//   q_push       : push attempted this cycle
//   q_push_valid : push accepted
//   q_pop        : handshake completed
//   q_pop_valid  : FIFO non-empty
//   level        : occupancy
//   overflow     : sticky, an entry was dropped
module event_scheduler #(
    parameter int N_IN      = 2,
    parameter int DW        = 64,
    parameter int TS_W      = 32,
    parameter int DEPTH     = 4,
    parameter int P0_PERIOD = 1000,
    parameter int P1_PERIOD = 2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_IN*DW-1:0]        in_data,
    input  logic [N_IN-1:0]           in_new,
    event_scheduler_if.master         ev,
    output logic                      q_push,
    output logic                      q_push_valid,
    output logic                      q_pop,
    output logic                      q_pop_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int C0W = $clog2(P0_PERIOD);
    localparam int C1W = $clog2(P1_PERIOD);
    localparam int PW  = N_IN + 2;

    logic [TS_W-1:0]    ts_q,   ts_d;
    logic [C0W-1:0]     c0_q,   c0_d;
    logic [C1W-1:0]     c1_q,   c1_d;
    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic               ovf_q,  ovf_d;

    logic [N_IN*DW-1:0] mem_data   [DEPTH];
    logic [PW-1:0]      mem_pacing [DEPTH];
    logic [TS_W-1:0]    mem_ts     [DEPTH];

    logic               dl0, dl1;
    logic [PW-1:0]      pacing_w;
    logic [N_IN*DW-1:0] data_w;
    logic               empty, full, pop_w, push_ok;

    assign dl0      = (c0_q == C0W'(P0_PERIOD - 1));
    assign dl1      = (c1_q == C1W'(P1_PERIOD - 1));
    assign pacing_w = {dl1, dl0, in_new};

    always_comb begin
        data_w = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (in_new[i]) data_w[i*DW +: DW] = in_data[i*DW +: DW];
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Combinational strobes are gated by rst so every output reads 0
    // while reset is held, not only after the registers clear.
    assign q_push       = rst & en & (|pacing_w);
    assign pop_w        = rst & en & ~empty & ev.ev_ready;
    assign push_ok      = q_push & (~full | pop_w);
    assign q_push_valid = push_ok;
    assign q_pop        = pop_w;
    assign q_pop_valid  = ~empty;
    assign level        = wptr_q - rptr_q;
    assign overflow     = ovf_q;

    assign ev.ev_valid  = ~empty;
    assign ev.ev_data   = empty ? '0 : mem_data[rptr_q[AW-1:0]];
    assign ev.ev_pacing = empty ? '0 : mem_pacing[rptr_q[AW-1:0]];
    assign ev.ev_ts     = empty ? '0 : mem_ts[rptr_q[AW-1:0]];

    always_comb begin
        ts_d   = ts_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (en) begin
            ts_d = ts_q + TS_W'(1);
            c0_d = dl0 ? '0 : c0_q + C0W'(1);
            c1_d = dl1 ? '0 : c1_q + C1W'(1);
        end
        if (push_ok)           wptr_d = wptr_q + (AW+1)'(1);
        if (pop_w)             rptr_d = rptr_q + (AW+1)'(1);
        if (q_push && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q   <= '0;
            c0_q   <= '0;
            c1_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wptr_q[AW-1:0]]   <= data_w;
            mem_pacing[wptr_q[AW-1:0]] <= pacing_w;
            mem_ts[wptr_q[AW-1:0]]     <= ts_q;
        end
    end
endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;
    localparam int N_IN  = 2;
    localparam int DW    = 64;
    localparam int TS_W  = 32;
    localparam int DEPTH = 4;
    localparam int P0    = 4;
    localparam int P1    = 8;

    typedef struct {
        logic [N_IN*DW-1:0] d;
        logic [N_IN+1:0]    p;
        logic [TS_W-1:0]    t;
    } entry_t;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [N_IN*DW-1:0]     in_data;
    logic [N_IN-1:0]        in_new;
    logic                   q_push, q_push_valid, q_pop, q_pop_valid;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    event_scheduler_if #(.N_IN(N_IN), .DW(DW), .TS_W(TS_W)) evif ();

    event_scheduler #(
        .N_IN(N_IN), .DW(DW), .TS_W(TS_W), .DEPTH(DEPTH),
        .P0_PERIOD(P0), .P1_PERIOD(P1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_data(in_data), .in_new(in_new),
        .ev(evif),
        .q_push(q_push), .q_push_valid(q_push_valid),
        .q_pop(q_pop), .q_pop_valid(q_pop_valid),
        .level(level), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    entry_t          sb[$];
    logic [TS_W-1:0] ts_m;
    int              c0_m, c1_m;
    logic            ovf_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        ts_m  = '0;
        c0_m  = 0;
        c1_m  = 0;
        ovf_m = 1'b0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string ph);
        chk({ph, "_q_push"},       128'(q_push),        '0);
        chk({ph, "_q_push_valid"}, 128'(q_push_valid),  '0);
        chk({ph, "_q_pop"},        128'(q_pop),         '0);
        chk({ph, "_q_pop_valid"},  128'(q_pop_valid),   '0);
        chk({ph, "_level"},        128'(level),         '0);
        chk({ph, "_overflow"},     128'(overflow),      '0);
        chk({ph, "_ev_valid"},     128'(evif.ev_valid), '0);
        chk({ph, "_ev_data"},      128'(evif.ev_data),  '0);
        chk({ph, "_ev_pacing"},    128'(evif.ev_pacing),'0);
        chk({ph, "_ev_ts"},        128'(evif.ev_ts),    '0);
    endtask

    // One clock cycle: inputs are already driven; compare at the falling
    // edge, update the model, then move to just after the rising edge.
    task automatic cycle(input string ph);
        logic [N_IN+1:0]    pac;
        logic [N_IN*DW-1:0] dat;
        logic               e_push, e_pop, e_pv, is_full;
        int                 lvl;
        entry_t             e;
        @(negedge clk);
        lvl     = sb.size();
        is_full = (lvl == DEPTH);
        pac     = {(c1_m == P1 - 1), (c0_m == P0 - 1), in_new};
        dat     = '0;
        for (int i = 0; i < N_IN; i++)
            if (in_new[i]) dat[i*DW +: DW] = in_data[i*DW +: DW];
        e_push = en && (pac != '0);
        e_pop  = en && (lvl != 0) && evif.ev_ready;
        e_pv   = e_push && (!is_full || e_pop);

        chk({ph, "_level"},        128'(level),         128'(lvl));
        chk({ph, "_ev_valid"},     128'(evif.ev_valid), 128'(lvl != 0));
        chk({ph, "_q_pop_valid"},  128'(q_pop_valid),   128'(lvl != 0));
        chk({ph, "_q_push"},       128'(q_push),        128'(e_push));
        chk({ph, "_q_push_valid"}, 128'(q_push_valid),  128'(e_pv));
        chk({ph, "_q_pop"},        128'(q_pop),         128'(e_pop));
        chk({ph, "_overflow"},     128'(overflow),      128'(ovf_m));
        if (lvl != 0) begin
            chk({ph, "_head_data"},   128'(evif.ev_data),   128'(sb[0].d));
            chk({ph, "_head_pacing"}, 128'(evif.ev_pacing), 128'(sb[0].p));
            chk({ph, "_head_ts"},     128'(evif.ev_ts),     128'(sb[0].t));
        end else begin
            chk({ph, "_empty_data"},   128'(evif.ev_data),   '0);
            chk({ph, "_empty_pacing"}, 128'(evif.ev_pacing), '0);
            chk({ph, "_empty_ts"},     128'(evif.ev_ts),     '0);
        end

        if (e_pop) void'(sb.pop_front());
        if (e_pv) begin
            e.d = dat; e.p = pac; e.t = ts_m;
            sb.push_back(e);
        end
        if (e_push && !e_pv) ovf_m = 1'b1;
        if (en) begin
            ts_m = ts_m + 1;
            c0_m = (c0_m == P0 - 1) ? 0 : c0_m + 1;
            c1_m = (c1_m == P1 - 1) ? 0 : c1_m + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [DW-1:0] v0, v1;
        bit                   reached;
        model_reset();
        // reset held with active-looking inputs: everything reads 0
        rst           = 1'b0;
        en            = 1'b1;
        in_new        = 2'b11;
        in_data       = {64'd9, 64'd8};
        evif.ev_ready = 1'b1;
        #2;
        check_all_zero("por");
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_new = '0;

        // periodic deadlines only, ready=1
        for (int i = 0; i < 3; i++) cycle("per");
        // coincident input event at ts 3
        v0      = 64'sd5;
        v1      = -64'sd7;
        in_data = {v1, v0};
        in_new  = 2'b11;
        cycle("coinc");
        in_new  = '0;
        in_data = '0;
        for (int i = 0; i < 13; i++) cycle("per2");

        // fill with ready low, overflow on 5th push
        evif.ev_ready = 1'b0;
        in_new        = 2'b01;
        for (int i = 0; i < 6; i++) begin
            in_data = {64'd0, $urandom, $urandom};
            cycle("fill");
        end
        // push while full and popping: accepted, level holds
        evif.ev_ready = 1'b1;
        in_data       = {64'd0, 64'h1234_5678_9abc_def0};
        cycle("fullpp");
        // drain
        in_new  = '0;
        in_data = '0;
        for (int i = 0; i < 6; i++) cycle("drain");

        // enable low for 10 cycles with occupancy
        evif.ev_ready = 1'b0;
        in_new        = 2'b01;
        for (int i = 0; i < 2; i++) begin
            in_data = {64'd0, 64'(100 + i)};
            cycle("prefill");
        end
        en            = 1'b0;
        evif.ev_ready = 1'b1;
        in_new        = 2'b11;
        in_data       = {64'd77, 64'd66};
        for (int i = 0; i < 10; i++) cycle("dis");
        en      = 1'b1;
        in_new  = '0;
        in_data = '0;
        for (int i = 0; i < 8; i++) cycle("resume");

        // build level 3 then reset between edges
        evif.ev_ready = 1'b0;
        in_new        = 2'b01;
        reached       = 1'b0;
        for (int i = 0; i < 8 && !reached; i++) begin
            in_data = {64'd0, 64'(200 + i)};
            cycle("lvl3");
            if (sb.size() == 3) reached = 1'b1;
        end
        chk("lvl3_level", 128'(level), 128'd3);
        chk("lvl3_overflow", 128'(overflow), 128'd1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        in_new = '0;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        evif.ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
